// File: rtl/modulo_sensor_spi_if.sv
// Bus bundle between system logic, the SPI master and the sensor pins.
// The master modport is the controller's view; slave is the environment's view.
interface modulo_sensor_spi_if;
  logic       miso;
  logic [7:0] data_in;
  logic       read_en;
  logic       cs;
  logic       sck;
  logic       mosi;
  logic [7:0] data_out;
  logic [7:0] contador;

  modport master (
    input  miso, data_in, read_en,
    output cs, sck, mosi, data_out, contador
  );

  modport slave (
    output miso, data_in, read_en,
    input  cs, sck, mosi, data_out, contador
  );
endinterface

// File: rtl/modulo_sensor_spi.sv
// Free-running SPI mode-0 master: back-to-back write (8-bit) or command+read
// (16-bit) frames separated by an idle gap, with a completed-frame counter.
module modulo_sensor_spi #(
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned IDLE_CYCLES = 4
) (
  input logic                  clk,
  input logic                  reset,
  modulo_sensor_spi_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam logic [8:0] HALF_LAST = 9'(CLK_DIV - 1);
  localparam logic [8:0] BIT_LAST  = 9'(2 * CLK_DIV - 1);
  localparam logic [8:0] IDLE_LAST = 9'(IDLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [4:0]  bit_q, bit_d;
  logic [15:0] shift_q, shift_d;
  logic [7:0]  rx_q, rx_d;
  logic        rd_q, rd_d;
  logic        cs_q, cs_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;
  logic [7:0]  data_out_q, data_out_d;
  logic [7:0]  contador_q, contador_d;
  logic [4:0]  bit_last_s;

  assign bit_last_s = rd_q ? 5'd15 : 5'd7;

  // Next-state and next-output logic; outputs are computed one edge ahead so they leave flops.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 9'd1;
    bit_d      = bit_q;
    shift_d    = shift_q;
    rx_d       = rx_q;
    rd_d       = rd_q;
    cs_d       = cs_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    data_out_d = data_out_q;
    contador_d = contador_q;

    case (state_q)
      IDLE: begin
        cs_d   = 1'b1;
        sck_d  = 1'b0;
        mosi_d = 1'b0;
        if (cnt_q == IDLE_LAST) begin
          state_d = SETUP;
          cnt_d   = 9'd0;
          bit_d   = 5'd0;
          shift_d = {bus.data_in, 8'h00};
          rd_d    = bus.read_en;
          cs_d    = 1'b0;
          mosi_d  = bus.data_in[7];
        end else begin
          state_d = IDLE;
        end
      end

      SETUP: begin
        if (cnt_q == HALF_LAST) begin
          state_d = SHIFT;
          cnt_d   = 9'd0;
        end else begin
          state_d = SETUP;
        end
      end

      SHIFT: begin
        // End of the high phase is the sck falling edge: advance mosi or finish.
        if (cnt_q == BIT_LAST) begin
          cnt_d = 9'd0;
          sck_d = 1'b0;
          if (bit_q == bit_last_s) begin
            state_d = HOLD;
            mosi_d  = 1'b0;
          end else begin
            bit_d   = bit_q + 5'd1;
            shift_d = {shift_q[14:0], 1'b0};
            mosi_d  = shift_q[14];
          end
        end else if (cnt_q == HALF_LAST) begin
          sck_d = 1'b1;
          rx_d  = {rx_q[6:0], bus.miso};
        end else begin
          sck_d = sck_q;
        end
      end

      HOLD: begin
        if (cnt_q == HALF_LAST) begin
          state_d    = IDLE;
          cnt_d      = 9'd0;
          cs_d       = 1'b1;
          contador_d = contador_q + 8'd1;
          if (rd_q) begin
            data_out_d = rx_q;
          end else begin
            data_out_d = data_out_q;
          end
        end else begin
          state_d = HOLD;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 9'd0;
        cs_d    = 1'b1;
        sck_d   = 1'b0;
        mosi_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset that aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 9'd0;
      bit_q      <= 5'd0;
      shift_q    <= 16'h0000;
      rx_q       <= 8'h00;
      rd_q       <= 1'b0;
      cs_q       <= 1'b1;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      data_out_q <= 8'h00;
      contador_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      rx_q       <= rx_d;
      rd_q       <= rd_d;
      cs_q       <= cs_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      data_out_q <= data_out_d;
      contador_q <= contador_d;
    end
  end

  assign bus.cs       = cs_q;
  assign bus.sck      = sck_q;
  assign bus.mosi     = mosi_q;
  assign bus.data_out = data_out_q;
  assign bus.contador = contador_q;

endmodule

// File: tb/tb_modulo_sensor_spi.sv
// Directed bench for modulo_sensor_spi with default parameters (CLK_DIV=2, IDLE_CYCLES=4).
module tb_modulo_sensor_spi;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   rises;
  int   cs_low;
  int   cycles;
  int   sck_viol;
  logic sck_prev;
  logic rd_mode;
  logic [7:0]  resp;
  logic [15:0] mosi_log;

  modulo_sensor_spi_if bus ();

  modulo_sensor_spi dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge, log sck rises, respond on miso after sck falls.
  task automatic tick();
    @(negedge clk);
    cycles++;
    if (bus.sck && !sck_prev) begin
      rises++;
      mosi_log = {mosi_log[14:0], bus.mosi};
    end
    if (!bus.sck && sck_prev && rd_mode) begin
      if (rises >= 8 && rises <= 15) bus.miso = resp[15 - rises];
      else bus.miso = 1'b0;
    end
    sck_prev = bus.sck;
    if (!bus.cs) cs_low++;
    if (bus.cs && bus.sck) sck_viol++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_cs(input logic lvl, input string tag);
    int n;
    n = 0;
    while (bus.cs !== lvl && n < 300) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.cs), 32'(lvl));
  endtask

  task automatic clear_stats();
    rises    = 0;
    cs_low   = 0;
    cycles   = 0;
    mosi_log = 16'h0000;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    sck_viol = 0;
    sck_prev = 1'b0;
    rd_mode  = 1'b0;
    resp     = 8'h5A;
    clear_stats();
    reset        = 1'b1;
    bus.data_in  = 8'h33;
    bus.read_en  = 1'b0;
    bus.miso     = 1'b0;

    // Reset state
    ticks(2);
    check("rst_cs",       32'(bus.cs),       32'd1);
    check("rst_sck",      32'(bus.sck),      32'd0);
    check("rst_mosi",     32'(bus.mosi),     32'd0);
    check("rst_contador", 32'(bus.contador), 32'd0);
    check("rst_data_out", 32'(bus.data_out), 32'd0);

    // Release; cs falls on the 4th edge after release
    reset = 1'b0;
    clear_stats();
    ticks(3);
    check("cs_high_before_first", 32'(bus.cs), 32'd1);
    tick();
    check("first_cs_fall", 32'(bus.cs), 32'd0);
    check("setup_mosi_msb", 32'(bus.mosi), 32'd0);

    // Write frame 0x33; change data_in mid-frame to 0xFF
    ticks(20);
    bus.data_in = 8'hFF;
    wait_cs(1'b1, "frame1_end");
    check("frame1_cycles",   32'(cycles),        32'd40);
    check("frame1_cs_low",   32'(cs_low),        32'd36);
    check("frame1_rises",    32'(rises),         32'd8);
    check("frame1_mosi",     32'(mosi_log[7:0]), 32'h33);
    check("frame1_contador", 32'(bus.contador),  32'd1);
    check("frame1_data_out", 32'(bus.data_out),  32'd0);

    // Second frame completes exactly 80 clocks after release
    ticks(39);
    check("frame2_not_yet", 32'(bus.contador), 32'd1);
    tick();
    check("frame2_contador", 32'(bus.contador), 32'd2);
    check("frame2_cs",       32'(bus.cs),       32'd1);
    check("total_rises_80",  32'(rises),        32'd16);
    check("mosi_33_then_ff", 32'(mosi_log),     32'h33FF);

    // Read frame: command A5, sensor answers 5A
    bus.read_en = 1'b1;
    bus.data_in = 8'hA5;
    rd_mode     = 1'b1;
    clear_stats();
    wait_cs(1'b0, "read_start");
    check("read_start_cycles", 32'(cycles), 32'd4);
    wait_cs(1'b1, "read_end");
    check("read_rises",    32'(rises),        32'd16);
    check("read_cs_low",   32'(cs_low),       32'd68);
    check("read_mosi",     32'(mosi_log),     32'hA500);
    check("read_data_out", 32'(bus.data_out), 32'h5A);
    check("read_contador", 32'(bus.contador), 32'd3);

    // Write frame leaves data_out alone; then reset in the middle of SHIFT
    bus.read_en = 1'b0;
    bus.data_in = 8'h33;
    rd_mode     = 1'b0;
    bus.miso    = 1'b0;
    clear_stats();
    wait_cs(1'b0, "abort_frame_start");
    while (rises < 3 && cycles < 300) tick();
    check("abort_reached_shift", 32'(rises), 32'd3);
    reset = 1'b1;
    tick();
    check("abort_cs",       32'(bus.cs),       32'd1);
    check("abort_sck",      32'(bus.sck),      32'd0);
    check("abort_mosi",     32'(bus.mosi),     32'd0);
    check("abort_contador", 32'(bus.contador), 32'd0);
    check("abort_data_out", 32'(bus.data_out), 32'd0);
    reset = 1'b0;
    clear_stats();
    ticks(3);
    check("restart_cs_high", 32'(bus.cs), 32'd1);
    tick();
    check("restart_cs_fall", 32'(bus.cs), 32'd0);
    wait_cs(1'b1, "restart_end");
    check("restart_mosi",     32'(mosi_log[7:0]), 32'h33);
    check("restart_contador", 32'(bus.contador),  32'd1);
    check("restart_data_out", 32'(bus.data_out),  32'd0);

    check("sck_low_while_cs_high", 32'(sck_viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
